moore_stim_driver: RTL and testbench

- Programmable stimulus/checker that drives the input side of the 2-state Moore FSM (sw_in, ctrl_in) and scores its registered out against a stored expected sequence.
- Sits between the bench/config loader and the FSM under test. It presents one input symbol per step, pulses the step enable, and samples the FSM output on the following cycle.
- Reports pass/fail, mismatch count and the first failing step.

---
 rtl/moore_stim_driver.sv | 137 +++++++++++++
 tb/tb_moore_stim_driver.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/moore_stim_driver.sv
// Moore FSM stimulus driver and scorer.
// Replays a stored sequence of {switch symbol, expected out} entries into a
// 2-state Moore FSM, one step every two cycles (drive, then check), and
// reports the mismatch count and the first failing step.
module moore_stim_driver #(
  parameter int SW_W  = 2,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_en,
  input  logic [AW-1:0]   load_addr,
  input  logic [SW_W-1:0] load_sw,
  input  logic            load_exp,
  input  logic [AW:0]     len,
  input  logic            start,
  input  logic            dut_out,
  output logic [SW_W-1:0] sw_out,
  output logic            ctrl_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [AW:0]     err_cnt,
  output logic [AW-1:0]   fail_step
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  state_t state, next_state;

  // Each entry is {switch symbol, expected out}; deliberately not reset.
  logic [SW_W:0] mem [DEPTH];

  logic [AW-1:0]   idx;
  logic [AW:0]     len_q;
  logic [AW:0]     err_q;
  logic [AW-1:0]   fail_q;
  logic [SW_W-1:0] cur_sw;
  logic            cur_exp;
  logic            start_ok;
  logic            last_step;
  logic            mismatch;

  assign cur_sw    = mem[idx][SW_W:1];
  assign cur_exp   = mem[idx][0];
  assign start_ok  = start && ((state == IDLE) || (state == DONE));
  assign last_step = ({1'b0, idx} == (len_q - (AW+1)'(1)));
  assign mismatch  = (dut_out != cur_exp);

  assign err_cnt   = err_q;
  assign fail_step = fail_q;
  assign pass      = done && (err_q == '0);

  // State register; a low reset abandons any run immediately.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and Moore outputs; the step enable only exists in DRIVE.
  always_comb begin
    next_state = state;
    sw_out     = '0;
    ctrl_out   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = (len == '0) ? DONE : DRIVE;
        end
      end
      DRIVE: begin
        sw_out     = cur_sw;
        ctrl_out   = 1'b1;
        busy       = 1'b1;
        next_state = CHECK;
      end
      CHECK: begin
        sw_out     = cur_sw;
        busy       = 1'b1;
        next_state = last_step ? DONE : DRIVE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          next_state = (len == '0) ? DONE : DRIVE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Run bookkeeping: latch the clamped length on start, score each CHECK cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      idx    <= '0;
      len_q  <= '0;
      err_q  <= '0;
      fail_q <= '0;
    end else if (start_ok) begin
      idx    <= '0;
      len_q  <= (len > DEPTH_L) ? DEPTH_L : len;
      err_q  <= '0;
      fail_q <= '0;
    end else if (state == CHECK) begin
      if (mismatch) begin
        err_q <= err_q + (AW+1)'(1);
        if (err_q == '0) begin
          fail_q <= idx;
        end
      end
      if (!last_step) begin
        idx <= idx + AW'(1);
      end
    end
  end

  // Sequence memory writes are locked out while a run is in progress.
  always_ff @(posedge clk) begin
    if (load_en && !busy) begin
      mem[load_addr] <= {load_sw, load_exp};
    end
  end

endmodule

// File: tb/tb_moore_stim_driver.sv
// Testbench for moore_stim_driver.
// A small 2-state Moore FSM stand-in sits on the driver outputs. Symbol rules:
// 0 toggles, 1 clears, 2 holds, 3 sets; its out is the registered state,
// optionally inverted to model a broken FSM. Expected run results come from a
// behavioural model over the loaded sequence and are queued for a monitor
// that compares them whenever the driver raises done.
module tb_moore_stim_driver;

   localparam int SW_W  = 2;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   typedef struct {
      int err;
      int fstep;
      bit passExp;
      int doneCyc;
      int pulses;
   } exp_t;

   logic            clk;
   logic            reset;
   logic            load_en;
   logic [AW-1:0]   load_addr;
   logic [SW_W-1:0] load_sw;
   logic            load_exp;
   logic [AW:0]     len;
   logic            start;
   logic            dut_out;
   logic [SW_W-1:0] sw_out;
   logic            ctrl_out;
   logic            busy;
   logic            done;
   logic            pass;
   logic [AW:0]     err_cnt;
   logic [AW-1:0]   fail_step;

   logic fsmSt;
   logic fsmClear;
   logic fsmInv;

   int   cyc;
   int   ctrlTotal;
   int   nCmp;
   int   nFail;
   bit   donePrev;
   bit   ctrlPrev;
   bit   startPrev;
   exp_t sbQ[$];

   int   mSw[DEPTH];
   bit   mExp[DEPTH];

   moore_stim_driver #(.SW_W(SW_W), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .load_en   (load_en),
      .load_addr (load_addr),
      .load_sw   (load_sw),
      .load_exp  (load_exp),
      .len       (len),
      .start     (start),
      .dut_out   (dut_out),
      .sw_out    (sw_out),
      .ctrl_out  (ctrl_out),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .err_cnt   (err_cnt),
      .fail_step (fail_step)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle counter used to time done against the start edge.
   always @(posedge clk) begin
      cyc <= cyc + 1;
   end

   // FSM stand-in driven by the step enable.
   always @(posedge clk) begin
      if (fsmClear) begin
         fsmSt <= 1'b0;
      end else if (ctrl_out) begin
         case (sw_out)
            2'd0: fsmSt <= ~fsmSt;
            2'd1: fsmSt <= 1'b0;
            2'd2: fsmSt <= fsmSt;
            default: fsmSt <= 1'b1;
         endcase
      end
   end

   assign dut_out = fsmSt ^ fsmInv;

   // One comparison; reports a FAIL line on disagreement.
   task automatic checkOutput(input string name, input int actual, input int expected);
      nCmp++;
      if (actual != expected) begin
         nFail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Reference model: walk the stand-in FSM over the first n entries.
   function automatic void predict(input int n, input bit inv, output int err, output int fstep);
      bit st;
      st = 1'b0;
      err = 0;
      fstep = 0;
      for (int i = 0; i < n; i++) begin
         case (mSw[i])
            0: st = ~st;
            1: st = 1'b0;
            2: st = st;
            default: st = 1'b1;
         endcase
         if ((st ^ inv) != mExp[i]) begin
            if (err == 0) fstep = i;
            err++;
         end
      end
   endfunction

   // Write one sequence entry and mirror it in the model.
   task automatic loadEntry(input int addr, input int sw, input bit ex);
      load_en   = 1'b1;
      load_addr = AW'(addr);
      load_sw   = SW_W'(sw);
      load_exp  = ex;
      @(posedge clk); #1;
      load_en   = 1'b0;
      mSw[addr]  = sw;
      mExp[addr] = ex;
   endtask

   // Rewrite every expected bit so a non-inverted FSM passes any length.
   task automatic makeConsistent();
      bit st;
      st = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         case (mSw[i])
            0: st = ~st;
            1: st = 1'b0;
            2: st = st;
            default: st = 1'b1;
         endcase
         loadEntry(i, mSw[i], st);
      end
   endtask

   // Clear the FSM, queue the expected result, start a run, wait for done.
   task automatic applyStimulus(input int n, input bit inv, input bit disturb);
      exp_t e;
      int   l;
      fsmInv   = inv;
      fsmClear = 1'b1;
      @(posedge clk); #1;
      fsmClear = 1'b0;
      l = (n > DEPTH) ? DEPTH : n;
      predict(l, inv, e.err, e.fstep);
      e.passExp = (e.err == 0);
      e.doneCyc = cyc + 2 * l + 1;
      e.pulses  = ctrlTotal + l;
      sbQ.push_back(e);
      start = 1'b1;
      len   = n[AW:0];
      @(posedge clk); #1;
      start = 1'b0;
      if (disturb) begin
         start     = 1'b1;
         len       = '0;
         load_en   = 1'b1;
         load_addr = AW'(1);
         load_sw   = SW_W'(3 - mSw[1]);
         load_exp  = ~mExp[1];
         @(posedge clk); #1;
         start   = 1'b0;
         load_en = 1'b0;
      end
      for (int k = 0; k < 2 * DEPTH + 8 && sbQ.size() != 0; k++) begin
         @(posedge clk);
      end
      #1;
      if (sbQ.size() != 0) begin
         nCmp++;
         nFail++;
         $display("[TB] FAIL done_timeout: got no done, expected done for len %0d", n);
         sbQ.delete();
      end
   endtask

   // Monitor: step-enable shape every cycle, run results whenever done appears.
   always @(negedge clk) begin
      exp_t e;
      if (ctrl_out === 1'b1) begin
         checkOutput("ctrl_back_to_back", int'(ctrlPrev), 0);
         ctrlTotal++;
      end
      if (done === 1'b1 && (!donePrev || startPrev)) begin
         if (sbQ.size() == 0) begin
            nCmp++;
            nFail++;
            $display("[TB] FAIL unexpected_done: got done=1, expected no run");
         end else begin
            e = sbQ.pop_front();
            checkOutput("err_cnt", int'(err_cnt), e.err);
            checkOutput("pass", int'(pass), int'(e.passExp));
            if (!e.passExp) checkOutput("fail_step", int'(fail_step), e.fstep);
            checkOutput("done_cycle", cyc, e.doneCyc);
            checkOutput("ctrl_pulses", ctrlTotal, e.pulses);
         end
      end
      donePrev  = (done === 1'b1);
      ctrlPrev  = (ctrl_out === 1'b1);
      startPrev = (start === 1'b1);
   end

   // Hard stop in case something wedges outside the bounded waits.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main stimulus sequence.
   initial begin
      int base;
      int n;
      bit inv;
      cyc       = 0;
      ctrlTotal = 0;
      nCmp      = 0;
      nFail     = 0;
      donePrev  = 1'b0;
      ctrlPrev  = 1'b0;
      startPrev = 1'b0;
      reset     = 1'b0;
      load_en   = 1'b0;
      load_addr = '0;
      load_sw   = '0;
      load_exp  = 1'b0;
      len       = '0;
      start     = 1'b0;
      fsmClear  = 1'b1;
      fsmInv    = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         mSw[i]  = 0;
         mExp[i] = 1'b0;
      end

      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_sw_out", int'(sw_out), 0);
      checkOutput("reset_ctrl_out", int'(ctrl_out), 0);
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_done", int'(done), 0);
      checkOutput("reset_pass", int'(pass), 0);
      checkOutput("reset_err_cnt", int'(err_cnt), 0);
      checkOutput("reset_fail_step", int'(fail_step), 0);
      reset    = 1'b1;
      fsmClear = 1'b0;

      // Directed runs over sw 0,1,2,3 / exp 1,0,0,1.
      for (int i = 0; i < DEPTH; i++) loadEntry(i, i % 4, 1'b0);
      loadEntry(0, 0, 1'b1);
      loadEntry(1, 1, 1'b0);
      loadEntry(2, 2, 1'b0);
      loadEntry(3, 3, 1'b1);
      applyStimulus(4, 1'b0, 1'b0);
      applyStimulus(4, 1'b1, 1'b0);
      loadEntry(2, 2, 1'b1);
      applyStimulus(4, 1'b0, 1'b0);
      loadEntry(2, 2, 1'b0);
      applyStimulus(0, 1'b0, 1'b0);

      // Reset during the CHECK cycle of step 1.
      fsmInv   = 1'b0;
      fsmClear = 1'b1;
      @(posedge clk); #1;
      fsmClear = 1'b0;
      base  = ctrlTotal;
      start = 1'b1;
      len   = 5'd4;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      checkOutput("midrun_busy_before", int'(busy), 1);
      checkOutput("midrun_ctrl_before", int'(ctrl_out), 0);
      checkOutput("midrun_pulses_before", ctrlTotal - base, 2);
      reset = 1'b0;
      @(posedge clk); #1;
      checkOutput("midrun_busy_after", int'(busy), 0);
      checkOutput("midrun_done_after", int'(done), 0);
      checkOutput("midrun_err_after", int'(err_cnt), 0);
      checkOutput("midrun_ctrl_after", int'(ctrl_out), 0);
      reset = 1'b1;
      @(posedge clk); #1;
      checkOutput("midrun_ctrl_idle", int'(ctrl_out), 0);
      applyStimulus(4, 1'b0, 1'b0);

      // start and load_en while busy must be ignored; rerun shows memory intact.
      applyStimulus(4, 1'b0, 1'b1);
      applyStimulus(4, 1'b0, 1'b0);

      // Randomized runs, including over-length requests.
      for (int it = 0; it < 25; it++) begin
         repeat ($urandom_range(1, 4)) begin
            loadEntry(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 3)),
                      bit'($urandom_range(0, 1)));
         end
         if ($urandom_range(0, 1) == 1) makeConsistent();
         inv = ($urandom_range(0, 3) == 0);
         n   = int'($urandom_range(0, 2 * DEPTH - 1));
         applyStimulus(n, inv, 1'b0);
      end

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
      $finish;
   end

endmodule
